v810_intc: RTL and testbench



---
 rtl/v810_intc_pkg.sv | 14 +
 rtl/v810_intc_prio.sv | 29 ++
 rtl/v810_intc.sv | 176 +++++++++++++++++
 tb/tb_v810_intc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/v810_intc_pkg.sv
// v810_intc_pkg: shared register indices and types for the V810 interrupt controller.
// Imported by v810_intc and v810_intc_prio.
package v810_intc_pkg;

  localparam logic [2:0] INTC_PEND  = 3'd0;
  localparam logic [2:0] INTC_MASK  = 3'd1;
  localparam logic [2:0] INTC_MODE  = 3'd2;
  localparam logic [2:0] INTC_STAT  = 3'd3;
  localparam logic [2:0] INTC_PRIO0 = 3'd4;

  typedef logic [3:0] level_t;
  typedef logic [4:0] src_idx_t;

endpackage

// File: rtl/v810_intc_prio.sv
// v810_intc_prio: picks the highest-priority active source.
// Ties resolve to the lowest source index.
module v810_intc_prio
  import v810_intc_pkg::*;
#(
  parameter int NUM_SRC = 16
) (
  input  logic [NUM_SRC-1:0] active,
  input  level_t [NUM_SRC-1:0] prio,
  output logic               valid,
  output level_t             level,
  output src_idx_t           index
);

  // strict compare keeps the earlier (lower) index on equal levels
  always_comb begin
    valid = 1'b0;
    level = '0;
    index = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active[i] && (!valid || prio[i] > level)) begin
        valid = 1'b1;
        level = prio[i];
        index = src_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/v810_intc.sv
// v810_intc: interrupt controller driving V810 INT/INTVn/NMIn.
// Define V810_INTC_SYNC_EN to add 2-flop input synchronizers.
module v810_intc
  import v810_intc_pkg::*;
#(
  parameter int                  NUM_SRC   = 16,
  parameter int                  NMI_PULSE = 2,
  parameter logic [NUM_SRC-1:0]  RST_MODE  = '1
) (
  input  logic               CLK,
  input  logic               RESn,
  input  logic               CE,
  input  logic               SEL,
  input  logic               WR,
  input  logic [2:0]         ADDR,
  input  logic [31:0]        DI,
  output logic [31:0]        DO,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic               NMI_REQ,
  output logic               INT,
  output logic [3:0]         INTVn,
  output logic               NMIn
);

  logic [NUM_SRC-1:0] irq_s;
  logic               nmi_s;

`ifdef V810_INTC_SYNC_EN
  logic [NUM_SRC-1:0] irq_m;
  logic               nmi_m;

  // free-running synchronizers, deliberately not CE-gated
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      irq_m <= '0;
      irq_s <= '0;
      nmi_m <= 1'b0;
      nmi_s <= 1'b0;
    end else begin
      irq_m <= IRQ;
      irq_s <= irq_m;
      nmi_m <= NMI_REQ;
      nmi_s <= nmi_m;
    end
  end
`else
  assign irq_s = IRQ;
  assign nmi_s = NMI_REQ;
`endif

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] irq_q;
  level_t [NUM_SRC-1:0] prio_q;
  src_idx_t           idx_q;
  logic               nmi_q;
  logic [3:0]         nmi_cnt;
  logic [31:0]        rdata;

  logic wr_en;
  logic rd_en;
  logic is_pend;
  logic is_mask;
  logic is_mode;
  logic is_stat;
  logic is_prio;

  assign wr_en   = CE & SEL & WR;
  assign rd_en   = CE & SEL & ~WR;
  assign is_pend = ADDR == INTC_PEND;
  assign is_mask = ADDR == INTC_MASK;
  assign is_mode = ADDR == INTC_MODE;
  assign is_stat = ADDR == INTC_STAT;
  assign is_prio = ADDR >= INTC_PRIO0;

  logic               win_vld;
  level_t             win_lvl;
  src_idx_t           win_idx;

  v810_intc_prio #(
    .NUM_SRC(NUM_SRC)
  ) u_prio (
    .active(pend & mask),
    .prio  (prio_q),
    .valid (win_vld),
    .level (win_lvl),
    .index (win_idx)
  );

  // next pending: edge bits latch (set beats W1C), level bits mirror IRQ
  always_comb begin
    logic [NUM_SRC-1:0] set;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] drop;
    set  = irq_s & ~irq_q;
    clr  = (wr_en && is_pend) ? DI[NUM_SRC-1:0] : '0;
    drop = (wr_en && is_mode) ? (mode & ~DI[NUM_SRC-1:0]) : '0;
    pend_nxt = (mode & ((pend & ~clr & ~drop) | set))
             | (~mode & irq_s);
  end

  // pending, edge history and software-visible config
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      pend  <= '0;
      irq_q <= '0;
      mask  <= '0;
      mode  <= RST_MODE;
      for (int i = 0; i < NUM_SRC; i++)
        prio_q[i] <= level_t'(i % 16);
    end else if (CE) begin
      pend  <= pend_nxt;
      irq_q <= irq_s;
      if (wr_en && is_mask) mask <= DI[NUM_SRC-1:0];
      if (wr_en && is_mode) mode <= DI[NUM_SRC-1:0];
      for (int i = 0; i < NUM_SRC; i++)
        if (wr_en && is_prio && ADDR[1:0] == 2'(i / 8))
          prio_q[i] <= DI[4*(i%8)+:4];
    end
  end

  // registered CPU-facing interrupt outputs
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      INT   <= 1'b0;
      INTVn <= 4'hF;
      idx_q <= '0;
    end else if (CE) begin
      INT   <= win_vld;
      INTVn <= win_vld ? ~win_lvl : 4'hF;
      idx_q <= win_vld ? win_idx : '0;
    end
  end

  // register read mux
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_pend: rdata = 32'(pend);
      is_mask: rdata = 32'(mask);
      is_mode: rdata = 32'(mode);
      is_stat: rdata = {INT, 11'b0, ~INTVn, 11'b0, idx_q};
      is_prio: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (ADDR[1:0] == 2'(i / 8))
            rdata[4*(i%8)+:4] = prio_q[i];
      end
      default: rdata = '0;
    endcase
  end

  // read data holds until the next read strobe
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) DO <= '0;
    else if (rd_en) DO <= rdata;
  end

  // NMI pulse stretcher; edges during a pulse are dropped
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      nmi_q   <= 1'b0;
      nmi_cnt <= '0;
    end else if (CE) begin
      nmi_q <= nmi_s;
      if (nmi_cnt != 4'd0)
        nmi_cnt <= nmi_cnt - 4'd1;
      else if (nmi_s && !nmi_q)
        nmi_cnt <= 4'(NMI_PULSE);
    end
  end

  assign NMIn = (nmi_cnt == 4'd0);

endmodule

// File: tb/tb_v810_intc.sv
// tb_v810_intc: directed self-checking bench for v810_intc.
// Register reads go through an expectation queue.
module tb_v810_intc;

  logic        CLK;
  logic        RESn;
  logic        CE;
  logic        SEL;
  logic        WR;
  logic [2:0]  ADDR;
  logic [31:0] DI;
  logic [31:0] DO;
  logic [15:0] IRQ;
  logic        NMI_REQ;
  logic        INT;
  logic [3:0]  INTVn;
  logic        NMIn;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  v810_intc dut (
    .CLK    (CLK),
    .RESn   (RESn),
    .CE     (CE),
    .SEL    (SEL),
    .WR     (WR),
    .ADDR   (ADDR),
    .DI     (DI),
    .DO     (DO),
    .IRQ    (IRQ),
    .NMI_REQ(NMI_REQ),
    .INT    (INT),
    .INTVn  (INTVn),
    .NMIn   (NMIn)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    SEL  = 1'b1;
    WR   = 1'b1;
    ADDR = a;
    DI   = d;
    step();
    SEL  = 1'b0;
    WR   = 1'b0;
    DI   = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a,
                    input logic [31:0] e);
    exp_t x;
    SEL  = 1'b1;
    WR   = 1'b0;
    ADDR = a;
    sb.push_back('{tag, e});
    step();
    SEL = 1'b0;
    x = sb.pop_front();
    chk(x.tag, DO, x.exp);
  endtask

  initial begin
    int low;
    RESn = 1'b0;
    CE = 1'b1;
    SEL = 1'b0;
    WR = 1'b0;
    ADDR = '0;
    DI = '0;
    IRQ = '0;
    NMI_REQ = 1'b0;
    step();
    step();
    chk("rst_int", 32'(INT), 32'd0);
    chk("rst_intvn", 32'(INTVn), 32'hF);
    chk("rst_nmin", 32'(NMIn), 32'd1);
    chk("rst_do", DO, 32'd0);
    RESn = 1'b1;
    step();

    rd("rst_mode", 3'd2, 32'h0000_FFFF);
    rd("rst_prio0", 3'd4, 32'h7654_3210);
    rd("rst_prio1", 3'd5, 32'hFEDC_BA98);
    rd("rst_prio2", 3'd6, 32'h0);
    rd("rst_pend", 3'd0, 32'h0);

    // level mode on source 8
    wr(3'd2, 32'h0);
    wr(3'd1, 32'h100);
    IRQ = 16'h0100;
    step();
    chk("lvl_int_n1", 32'(INT), 32'd0);
    step();
    chk("lvl_int_n2", 32'(INT), 32'd1);
    chk("lvl_intvn", 32'(INTVn), 32'h7);
    rd("lvl_stat", 3'd3, 32'h8008_0008);
    IRQ = '0;
    step();
    chk("lvl_drop_n1", 32'(INT), 32'd1);
    step();
    chk("lvl_drop_n2", 32'(INT), 32'd0);

    // edge mode on source 3
    wr(3'd2, 32'h0000_FFFF);
    wr(3'd1, 32'h08);
    IRQ = 16'h0008;
    step();
    IRQ = '0;
    step();
    step();
    rd("edge_pend", 3'd0, 32'h8);
    chk("edge_int", 32'(INT), 32'd1);
    chk("edge_intvn", 32'(INTVn), 32'hC);
    wr(3'd0, 32'h8);
    chk("w1c_int_n1", 32'(INT), 32'd1);
    step();
    chk("w1c_int_n2", 32'(INT), 32'd0);
    rd("w1c_pend", 3'd0, 32'h0);
    IRQ = 16'h0008;
    step();
    IRQ = '0;
    step();
    IRQ = 16'h0008;
    wr(3'd0, 32'h8);
    IRQ = '0;
    rd("set_wins", 3'd0, 32'h8);
    wr(3'd0, 32'h8);
    rd("set_clr", 3'd0, 32'h0);

    // equal priority tie between sources 2 and 9
    wr(3'd4, 32'h7654_3C10);
    wr(3'd5, 32'hFEDC_BAC8);
    wr(3'd1, 32'h0204);
    IRQ = 16'h0204;
    step();
    IRQ = '0;
    step();
    chk("tie_int", 32'(INT), 32'd1);
    chk("tie_intvn", 32'(INTVn), 32'h3);
    rd("tie_stat", 3'd3, 32'h800C_0002);
    wr(3'd1, 32'h0200);
    step();
    rd("tie_stat_m", 3'd3, 32'h800C_0009);
    chk("tie_intvn_m", 32'(INTVn), 32'h3);
    wr(3'd0, 32'h0204);
    wr(3'd1, 32'h0);
    step();
    step();
    chk("tie_clr_int", 32'(INT), 32'd0);

    // masked pending source 7
    IRQ = 16'h0080;
    step();
    IRQ = '0;
    step();
    step();
    chk("msk_int", 32'(INT), 32'd0);
    rd("msk_stat", 3'd3, 32'h0);
    rd("msk_pend", 3'd0, 32'h80);
    wr(3'd1, 32'h80);
    chk("unmsk_n1", 32'(INT), 32'd0);
    step();
    chk("unmsk_n2", 32'(INT), 32'd1);
    chk("unmsk_intvn", 32'(INTVn), 32'h8);

    // single NMI edge
    low = 0;
    NMI_REQ = 1'b1;
    step();
    if (!NMIn) low++;
    NMI_REQ = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (!NMIn) low++;
    end
    chk("nmi_low", 32'(low), 32'd2);

    // second edge during pulse is ignored
    low = 0;
    NMI_REQ = 1'b1;
    step();
    if (!NMIn) low++;
    NMI_REQ = 1'b0;
    step();
    if (!NMIn) low++;
    NMI_REQ = 1'b1;
    step();
    if (!NMIn) low++;
    NMI_REQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!NMIn) low++;
    end
    chk("nmi_retrig", 32'(low), 32'd2);

    // CE stall mid pulse
    low = 0;
    NMI_REQ = 1'b1;
    step();
    if (!NMIn) low++;
    NMI_REQ = 1'b0;
    CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nmi_stall", 32'(NMIn), 32'd0);
    end
    CE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!NMIn) low++;
    end
    chk("nmi_ce_low", 32'(low), 32'd2);

    // async reset with INT and NMIn active
    NMI_REQ = 1'b1;
    step();
    chk("pre_rst_int", 32'(INT), 32'd1);
    chk("pre_rst_nmin", 32'(NMIn), 32'd0);
    #2;
    RESn = 1'b0;
    #1;
    chk("arst_int", 32'(INT), 32'd0);
    chk("arst_intvn", 32'(INTVn), 32'hF);
    chk("arst_nmin", 32'(NMIn), 32'd1);
    NMI_REQ = 1'b0;
    step();
    RESn = 1'b1;
    step();
    rd("arst_mode", 3'd2, 32'h0000_FFFF);
    rd("arst_prio0", 3'd4, 32'h7654_3210);
    rd("arst_mask", 3'd1, 32'h0);
    rd("arst_pend", 3'd0, 32'h0);
    chk("arst_nmin2", 32'(NMIn), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
